// File: rtl/input_arbiter_if.sv
// input_arbiter_if
//   Bundles the per-port input requests/flits, the queue-side write port and
//   the arbiter status outputs of input_arbiter.
//   master : the arbiter side (drives acknowledges, queue write, status)
//   slave  : the surrounding logic (drives requests, flits, queue full)
//   Signals:
//     wr_ready_in  [N]          per-port request
//     data_i       [BUS_SIZE*N] per-port flits, port i at [i*BUS_SIZE +: BUS_SIZE]
//     is_full                   queue full
//     r_ready_out  [N]          one-hot acknowledge to the granted port
//     wr_req                    queue write strobe
//     data_o       [BUS_SIZE]   flit written to the queue
//     owner        [IDX_W]      current/last granted port
//     busy                      high while a write is in progress
interface input_arbiter_if #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4,
  parameter int PORTS_NUM = 4
);
  localparam int N        = PORTS_NUM + 1;
  localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1;
  localparam int IDX_W    = $clog2(N);

  logic [N-1:0]          wr_ready_in;
  logic [BUS_SIZE*N-1:0] data_i;
  logic                  is_full;
  logic [N-1:0]          r_ready_out;
  logic                  wr_req;
  logic [BUS_SIZE-1:0]   data_o;
  logic [IDX_W-1:0]      owner;
  logic                  busy;

  modport master (
    input  wr_ready_in, data_i, is_full,
    output r_ready_out, wr_req, data_o, owner, busy
  );

  modport slave (
    output wr_ready_in, data_i, is_full,
    input  r_ready_out, wr_req, data_o, owner, busy
  );
endinterface

// File: rtl/input_arbiter.sv
// input_arbiter
//   Round-robin arbiter sharing the single queue write port among PORTS_NUM
//   mesh ports plus the local port (index PORTS_NUM). A grant is decided in
//   IDLE from the current inputs and written in the following ACK cycle, so at
//   most one flit is accepted every two cycles. The current owner may keep the
//   port for up to BURST_MAX consecutive grants, after which the scan starts
//   from the port after it.
//   Ports:
//     clk    clock, all state on the rising edge
//     a_rst  asynchronous active-low reset
//     bus    input_arbiter_if master modport (requests, flits, queue write,
//            acknowledges, owner, busy)
module input_arbiter #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4,
  parameter int PORTS_NUM = 4,
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             a_rst,
  input_arbiter_if.master  bus
);
  localparam int N        = PORTS_NUM + 1;
  localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1;
  localparam int IDX_W    = $clog2(N);
  localparam int CNT_W    = $clog2(BURST_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] LOCAL_IDX = IDX_W'(PORTS_NUM);
  localparam logic [N-1:0]     ONE_HOT0  = N'(1);

  typedef enum logic {IDLE, ACK} state_t;

  state_t              state_reg;
  logic [IDX_W-1:0]    owner_reg;
  logic                owner_vld_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [N-1:0]        r_ready_reg;
  logic                wr_req_reg;
  logic [BUS_SIZE-1:0] data_reg;
  logic                busy_reg;

  logic [BUS_SIZE-1:0] flit [N];
  logic                grant_ok;
  logic                keep_owner;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    scan_pos;
  logic [CNT_W-1:0]    cnt_next;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign flit[gi] = bus.data_i[gi*BUS_SIZE +: BUS_SIZE];
    end
  endgenerate

  always_comb begin
    keep_owner = owner_vld_reg && bus.wr_ready_in[owner_reg] && (cnt_reg < CNT_MAX);
    win_idx    = owner_reg;
    scan_pos   = owner_reg;
    if (!keep_owner) begin
      // Walk from the farthest candidate (owner itself) to the nearest
      // (owner+1); the last hit is the first requester after the owner.
      for (int k = N; k >= 1; k--) begin
        scan_pos = IDX_W'((int'(owner_reg) + k) % N);
        if (bus.wr_ready_in[scan_pos]) begin
          win_idx = scan_pos;
        end
      end
    end
    grant_ok = !bus.is_full && (|bus.wr_ready_in);

    if (owner_vld_reg && (win_idx == owner_reg)) begin
      cnt_next = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + CNT_ONE;
    end else begin
      cnt_next = CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state_reg     <= IDLE;
      owner_reg     <= LOCAL_IDX;
      owner_vld_reg <= 1'b0;
      cnt_reg       <= '0;
      r_ready_reg   <= '0;
      wr_req_reg    <= 1'b0;
      data_reg      <= '0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_ok) begin
            data_reg      <= flit[win_idx];
            r_ready_reg   <= ONE_HOT0 << win_idx;
            wr_req_reg    <= 1'b1;
            busy_reg      <= 1'b1;
            cnt_reg       <= cnt_next;
            owner_reg     <= win_idx;
            owner_vld_reg <= 1'b1;
            state_reg     <= ACK;
          end
        end
        ACK: begin
          // Requests are ignored here: the sender may still show the flit
          // that is being written right now.
          wr_req_reg  <= 1'b0;
          r_ready_reg <= '0;
          busy_reg    <= 1'b0;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.r_ready_out = r_ready_reg;
  assign bus.wr_req      = wr_req_reg;
  assign bus.data_o      = data_reg;
  assign bus.owner       = owner_reg;
  assign bus.busy        = busy_reg;
endmodule

// File: tb/tb_input_arbiter.sv
module tb_input_arbiter;
  localparam int DATA_SIZE = 32;
  localparam int ADDR_SIZE = 4;
  localparam int PORTS_NUM = 4;
  localparam int BURST_MAX = 4;
  localparam int N   = PORTS_NUM + 1;
  localparam int BUS = DATA_SIZE + ADDR_SIZE + 1;

  logic clk = 1'b0;
  logic a_rst;
  logic [N-1:0]   req;
  logic           full;
  logic [BUS-1:0] pdata [N];
  bit             drop_on_ack [N];

  int vectors = 0;
  int miscompares = 0;
  int glog[$];

  input_arbiter_if #(.DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE), .PORTS_NUM(PORTS_NUM)) bus ();

  input_arbiter #(
    .DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE),
    .PORTS_NUM(PORTS_NUM), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk  (clk),
    .a_rst(a_rst),
    .bus  (bus.master)
  );

  assign bus.wr_ready_in = req;
  assign bus.is_full     = full;
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign bus.data_i[gi*BUS +: BUS] = pdata[gi];
    end
  endgenerate

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Winner = owner while it keeps requesting and is under its burst budget,
  // otherwise the requester at the smallest rotational distance after owner.
  function automatic int pick(input logic [N-1:0] r, input int o, input bit v, input int c);
    int best;
    int bestd;
    int d;
    if (v && r[o] && c < BURST_MAX) return o;
    best  = -1;
    bestd = N;
    for (int p = 0; p < N; p++) begin
      if (r[p]) begin
        d = (p - o - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = p;
        end
      end
    end
    return best;
  endfunction

  bit             m_ack;
  int             m_owner;
  bit             m_vld;
  int             m_cnt;
  logic [BUS-1:0] m_data;
  int             m_win;

  always_comb m_win = pick(req, m_owner, m_vld, m_cnt);

  always @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      m_ack   <= 1'b0;
      m_owner <= PORTS_NUM;
      m_vld   <= 1'b0;
      m_cnt   <= 0;
      m_data  <= '0;
    end else if (m_ack) begin
      m_ack <= 1'b0;
    end else if (!full && req != '0) begin
      m_ack   <= 1'b1;
      m_data  <= pdata[m_win];
      m_cnt   <= (m_vld && m_win == m_owner) ? ((m_cnt + 1 > BURST_MAX) ? BURST_MAX : m_cnt + 1) : 1;
      m_owner <= m_win;
      m_vld   <= 1'b1;
    end
  end

  function automatic int onehot_idx(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) begin
      if (r == (N'(1) << i)) return i;
    end
    return 99;
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [N-1:0] exp_rr;
    exp_rr = m_ack ? (N'(1) << m_owner) : '0;
    chk("wr_req",      64'(bus.wr_req),      64'(m_ack));
    chk("r_ready_out", 64'(bus.r_ready_out), 64'(exp_rr));
    chk("data_o",      64'(bus.data_o),      64'(m_data));
    chk("owner",       64'(bus.owner),       64'(m_owner));
    chk("busy",        64'(bus.busy),        64'(m_ack));
  end

  // Grant history as seen on the DUT, for hand-computed sequence checks.
  always @(negedge clk) begin
    if (a_rst === 1'b1 && bus.wr_req === 1'b1) glog.push_back(onehot_idx(bus.r_ready_out));
  end

  task automatic chk_grant(input string name, input int i, input int exp);
    int act;
    act = (i < glog.size()) ? glog[i] : -1;
    chk($sformatf("%s[%0d]", name, i), 64'(act), 64'(exp));
  endtask

  // One clock; inputs change 1 time unit after the edge. Senders flagged
  // drop_on_ack release their request once acknowledged; every acked port
  // advances to a new flit.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (bus.r_ready_out[i]) begin
        pdata[i] = pdata[i] + BUS'(1);
        if (drop_on_ack[i]) req[i] = 1'b0;
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    a_rst = 1'b0;
    steps(2);
    a_rst = 1'b1;
  endtask

  initial begin
    logic [BUS-1:0] d1;
    bit seen;
    a_rst = 1'b1;
    req   = '0;
    full  = 1'b0;
    for (int i = 0; i < N; i++) begin
      pdata[i]       = BUS'((i + 1) << 24);
      drop_on_ack[i] = 1'b0;
    end
    #2;

    // Reset values with every port requesting
    a_rst = 1'b0;
    req   = '1;
    steps(3);
    chk("rst.wr_req",      64'(bus.wr_req),      64'(0));
    chk("rst.r_ready_out", 64'(bus.r_ready_out), 64'(0));
    chk("rst.data_o",      64'(bus.data_o),      64'(0));
    chk("rst.owner",       64'(bus.owner),       64'(4));
    chk("rst.busy",        64'(bus.busy),        64'(0));
    req            = 5'b00100;
    pdata[2]       = BUS'(37'h0A5);
    drop_on_ack[2] = 1'b1;
    a_rst          = 1'b1;
    step();
    chk("first.wr_req",      64'(bus.wr_req),      64'(1));
    chk("first.r_ready_out", 64'(bus.r_ready_out), 64'(5'b00100));
    chk("first.data_o",      64'(bus.data_o),      64'(37'h0A5));
    step();
    chk("first.one_cycle",   64'(bus.wr_req),      64'(0));
    steps(2);
    drop_on_ack[2] = 1'b0;

    // Burst lock: ports 0 and 3 requesting continuously
    req = 5'b01001;
    do_reset();
    glog.delete();
    steps(20);
    req = '0;
    steps(2);
    chk("burst.count", 64'(glog.size()), 64'(10));
    for (int i = 0; i < 10; i++) chk_grant("burst", i, ((i / 4) % 2 == 1) ? 3 : 0);

    // Round-robin fairness: single flits from all ports
    for (int i = 0; i < N; i++) drop_on_ack[i] = 1'b1;
    req = '1;
    do_reset();
    glog.delete();
    steps(14);
    chk("rr.count", 64'(glog.size()), 64'(5));
    for (int i = 0; i < 5; i++) chk_grant("rr", i, i);

    // Full backpressure on port 1
    full = 1'b1;
    req  = 5'b00010;
    glog.delete();
    steps(10);
    chk("full.no_grant", 64'(glog.size()), 64'(0));
    d1   = pdata[1];
    full = 1'b0;
    step();
    chk("full.wr_req",      64'(bus.wr_req),      64'(1));
    chk("full.r_ready_out", 64'(bus.r_ready_out), 64'(5'b00010));
    chk("full.data_o",      64'(bus.data_o),      64'(d1));
    steps(3);
    for (int i = 0; i < N; i++) drop_on_ack[i] = 1'b0;

    // Owner drop: port 2 owns with two grants, then yields to port 4
    req = 5'b00100;
    do_reset();
    steps(3);
    req = 5'b10000;
    step();
    glog.delete();
    step();
    req = 5'b10100;
    steps(9);
    req = '0;
    steps(2);
    chk("drop.count", 64'(glog.size()), 64'(5));
    for (int i = 0; i < 5; i++) chk_grant("drop", i, (i < 4) ? 4 : 2);

    // Reset asserted during ACK
    req  = 5'b00001;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (bus.wr_req === 1'b1) seen = 1'b1;
    end
    chk("midack.grant_seen", 64'(seen), 64'(1));
    a_rst = 1'b0;
    #1;
    chk("midack.wr_req",      64'(bus.wr_req),      64'(0));
    chk("midack.r_ready_out", 64'(bus.r_ready_out), 64'(0));
    chk("midack.busy",        64'(bus.busy),        64'(0));
    chk("midack.owner",       64'(bus.owner),       64'(4));
    steps(2);
    a_rst = 1'b1;
    step();
    chk("midack.regrant",     64'(bus.r_ready_out), 64'(5'b00001));
    req = '0;
    steps(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
